// File: rtl/sr_mon_pkg.sv
// Shared types for the sr_cpu debug register monitor.
package sr_mon_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {WATCH, DUMP} mon_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] idx;
        logic [DATA_W-1:0] data;
    } mon_rec_t;

endpackage

// File: rtl/sr_mon_fifo.sv
// Synchronous record FIFO; a push and a pop in the same cycle are legal when full.
module sr_mon_fifo
    import sr_mon_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  mon_rec_t pushRec,
    input  logic     pop,
    output mon_rec_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    mon_rec_t        mem [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [AW:0]     count;
    logic            doPush;
    logic            doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushRec;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sr_reg_monitor.sv
// Watches one sr_cpu register for changes, or dumps the whole file on request,
// emitting {index, value} records over a valid/ready stream.
module sr_reg_monitor
    import sr_mon_pkg::*;
#(
    parameter logic [4:0]  WATCH_REG  = 5'd10,
    parameter int unsigned NREGS      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [4:0]        regAddr,
    input  logic [31:0]       regData,
    input  logic              dump_req,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_reg,
    output logic [31:0]       out_data,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    mon_state_t        state, stateNext;
    logic [IDX_W-1:0]  idx, idxNext;
    logic [31:0]       prev, prevNext;
    logic              prevValid, prevValidNext;
    logic [DROP_W-1:0] dropNext;
    logic              pushEn;
    mon_rec_t          pushRec;
    mon_rec_t          head;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pushOk;

    assign out_valid = ~fifoEmpty;
    assign out_reg   = head.idx;
    assign out_data  = head.data;
    assign busy      = (state == DUMP);
    assign regAddr   = (state == DUMP) ? 5'(idx) : WATCH_REG;
    assign pushOk    = ~fifoFull | (out_valid & out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WATCH;
            idx       <= '0;
            prev      <= '0;
            prevValid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= stateNext;
            idx       <= idxNext;
            prev      <= prevNext;
            prevValid <= prevValidNext;
            drop_cnt  <= dropNext;
        end
    end

    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        prevNext      = prev;
        prevValidNext = prevValid;
        dropNext      = drop_cnt;
        pushEn        = 1'b0;
        pushRec       = '0;
        case (state)
            WATCH: begin
                if (dump_req) begin
                    stateNext = DUMP;
                    idxNext   = '0;
                end else if (!prevValid) begin
                    prevNext      = regData;
                    prevValidNext = 1'b1;
                end else if (regData != prev) begin
                    prevNext = regData;
                    if (pushOk) begin
                        pushEn       = 1'b1;
                        pushRec.idx  = WATCH_REG;
                        pushRec.data = regData;
                    end else if (drop_cnt != {DROP_W{1'b1}}) begin
                        dropNext = drop_cnt + DROP_W'(1);
                    end
                end
            end
            DUMP: begin
                // Without room the scan simply stalls on the current index.
                if (pushOk) begin
                    pushEn       = 1'b1;
                    pushRec.idx  = 5'(idx);
                    pushRec.data = regData;
                    if (idx == IDX_W'(NREGS - 1)) begin
                        stateNext     = WATCH;
                        prevValidNext = 1'b0;
                        idxNext       = '0;
                    end else begin
                        idxNext = idx + IDX_W'(1);
                    end
                end
            end
            default: stateNext = WATCH;
        endcase
    end

    sr_mon_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (pushEn),
        .pushRec(pushRec),
        .pop    (out_ready),
        .head   (head),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

endmodule
